ir_nec_receiver: RTL

Decodes NEC-protocol frames from the demodulated IR receiver pin into the 8-bit command code consumed by the drive-mode FSM. It holds the last valid command for as long as the button is held, including NEC repeat frames, and releases it to a "no button" code after a hold timeout. It sits directly upstream of the mode/drive FSM; its `ir_button` output connects to the FSM's `IR_button` input.

---
 rtl/ir_pkg.sv | 29 ++
 rtl/ir_edge_sync.sv | 25 ++
 rtl/ir_nec_receiver.sv | 110 +++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC receiver states, pulse-width windows and button codes
package ir_pkg;
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, TRAIL} ir_state_t;
  localparam logic [9:0] LEAD_MARK_MIN  = 10'd800;
  localparam logic [9:0] LEAD_MARK_MAX  = 10'd1000;
  localparam logic [9:0] LEAD_SPACE_MIN = 10'd400;
  localparam logic [9:0] LEAD_SPACE_MAX = 10'd500;
  localparam logic [9:0] REP_SPACE_MIN  = 10'd180;
  localparam logic [9:0] REP_SPACE_MAX  = 10'd270;
  localparam logic [9:0] BIT_MARK_MIN   = 10'd40;
  localparam logic [9:0] BIT_MARK_MAX   = 10'd70;
  localparam logic [9:0] BIT0_MIN       = 10'd40;
  localparam logic [9:0] BIT0_MAX       = 10'd70;
  localparam logic [9:0] BIT1_MIN       = 10'd140;
  localparam logic [9:0] BIT1_MAX       = 10'd190;
  localparam logic [9:0] WIDTH_MAX      = 10'd1023;
  localparam logic [7:0] IR_NONE        = 8'hFF;
  localparam logic [7:0] IR_CODE_0F     = 8'h0F;
  localparam logic [7:0] IR_CODE_10     = 8'h10;
  localparam logic [7:0] IR_CODE_13     = 8'h13;
  localparam logic [7:0] IR_CODE_0C     = 8'h0C;
  localparam logic [7:0] IR_CODE_14     = 8'h14;
  localparam logic [7:0] IR_CODE_18     = 8'h18;
  localparam logic [7:0] IR_CODE_1B     = 8'h1B;
  localparam logic [7:0] IR_CODE_1F     = 8'h1F;
  function automatic logic in_win(input logic [9:0] w, input logic [9:0] lo, input logic [9:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction
endpackage

// File: rtl/ir_edge_sync.sv
// ir_edge_sync: 2-FF synchronizer for the IR pin with registered level and rise/fall pulses
// Ports: clk_50, reset (sync, active-high), rx (async pin) -> level (synced), rise, fall (1-cycle pulses)
module ir_edge_sync (
  input  logic clk_50,
  input  logic reset,
  input  logic rx,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2;
  always_ff @(posedge clk_50) begin
    if (reset) begin
      {s1, s2, level} <= 3'b111;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      level <= s2;
      rise <= s2 & ~level;
      fall <= ~s2 & level;
    end
  end
endmodule

// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC frame decoder holding the last command until a repeat-less timeout
// Ports: clk_50, reset (sync, active-high), ir_rx (active-low pin) -> ir_button (0xFF = none),
//        ir_valid / ir_repeat / ir_err (1-cycle pulses)
module ir_nec_receiver
  import ir_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int HOLD_TICKS = 12000,
  parameter int ADDR_CHECK = 1
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       ir_rx,
  output logic [7:0] ir_button,
  output logic       ir_valid,
  output logic       ir_repeat,
  output logic       ir_err
);
  ir_state_t state, state_nx;
  logic level, rise, fall, tick, held, b0, b1, frame_ok, acc_d, acc_r, abort;
  logic [15:0] tick_cnt;
  logic [9:0] width;
  logic [13:0] hold_cnt;
  logic [31:0] sr, sr_nx, word;
  logic [4:0] idx, idx_nx;
  ir_edge_sync u_sync (.clk_50(clk_50), .reset(reset), .rx(ir_rx), .level(level), .rise(rise), .fall(fall));
  assign tick = tick_cnt == 16'(TICK_DIV - 1);
  assign held = ir_button != IR_NONE;
  assign b0 = in_win(width, BIT0_MIN, BIT0_MAX);
  assign b1 = in_win(width, BIT1_MIN, BIT1_MAX);
  assign word = {b1, sr[31:1]};
  assign frame_ok = (word[23:16] == ~word[31:24]) && (ADDR_CHECK == 0 || word[7:0] == ~word[15:8]);
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    idx_nx = idx;
    acc_d = 1'b0;
    acc_r = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE:       state_nx = fall ? LEAD_MARK : IDLE;
      LEAD_MARK:  if (rise) begin
        if (in_win(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_nx = LEAD_SPACE;
        else abort = 1'b1;
      end
      LEAD_SPACE: if (fall) begin
        if (in_win(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
          state_nx = BIT_MARK;
          idx_nx = 5'd0;
        end else if (in_win(width, REP_SPACE_MIN, REP_SPACE_MAX)) begin
          acc_r = 1'b1;
          state_nx = TRAIL;
        end else abort = 1'b1;
      end
      BIT_MARK:   if (rise) begin
        if (in_win(width, BIT_MARK_MIN, BIT_MARK_MAX)) state_nx = BIT_SPACE;
        else abort = 1'b1;
      end
      BIT_SPACE:  if (fall) begin
        if (!(b0 || b1)) abort = 1'b1;
        else begin
          sr_nx = word;
          if (idx == 5'd31) begin
            acc_d = frame_ok;
            abort = !frame_ok;
            state_nx = TRAIL;
          end else begin
            idx_nx = idx + 5'd1;
            state_nx = BIT_MARK;
          end
        end
      end
      TRAIL:      state_nx = rise ? IDLE : TRAIL;
      default:    state_nx = IDLE;
    endcase
    if (state != IDLE && !rise && !fall && width == WIDTH_MAX) abort = 1'b1;
    if (abort) state_nx = level ? IDLE : TRAIL;
  end
  // width is also cleared on abort so a stuck-low pin in TRAIL does not re-abort every cycle
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      tick_cnt <= '0;
      width <= '0;
      hold_cnt <= '0;
      ir_button <= IR_NONE;
      ir_valid <= 1'b0;
      ir_repeat <= 1'b0;
      ir_err <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      idx <= idx_nx;
      tick_cnt <= tick ? 16'd0 : tick_cnt + 16'd1;
      width <= (rise || fall || abort) ? 10'd0 : (tick && width != WIDTH_MAX) ? width + 10'd1 : width;
      ir_valid <= acc_d;
      ir_repeat <= acc_r && held;
      ir_err <= abort;
      if (acc_d || (acc_r && held)) begin
        hold_cnt <= '0;
        if (acc_d) ir_button <= sr_nx[23:16];
      end else if (tick && held) begin
        hold_cnt <= (hold_cnt == 14'(HOLD_TICKS - 1)) ? 14'd0 : hold_cnt + 14'd1;
        if (hold_cnt == 14'(HOLD_TICKS - 1)) ir_button <= IR_NONE;
      end
    end
  end
endmodule
